// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bnn_pkg
// Brief    : Shared constants and state encoding for the BNN weight-load path.
// Revision : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    localparam int NUM_NEURONS = 12;   // 8 layer-1 + 4 layer-2 weight bytes
    localparam int NUM_L1      = 8;
    localparam int NUM_L2      = 4;
    localparam int NIBBLE_W    = 4;
    localparam int IDX_W       = 5;

    // Position of the load signals on the core's bidirectional pin bus
    localparam int LOAD_EN_BIT = 3;
    localparam int NIB_LSB     = 4;

    // Streamer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } stream_state_e;

endpackage
`default_nettype wire

// File: rtl/bnn_weight_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bnn_weight_fifo
// Brief    : Small synchronous byte FIFO with flush and a look-ahead head port.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_weight_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers; flush overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bnn_weight_streamer
// Brief    : Buffers host weight bytes and streams one frame to the BNN core
//            as load-enabled nibbles, low nibble first.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_weight_streamer
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = bnn_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    input  logic             start,
    input  logic             abort,
    output logic             load_en,
    output logic [3:0]       weight_nib,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] neuron_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_head;

    stream_state_e    state_q,      state_d;
    logic             load_en_q,    load_en_d;
    logic [3:0]       weight_nib_q, weight_nib_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic [IDX_W-1:0] neuron_idx_q, neuron_idx_d;

    // Host may push in any state; ena low blocks pushes through s_ready
    assign s_ready = ena && !w_fifo_full;
    assign w_push  = s_valid && s_ready;

    bnn_weight_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (s_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_head)
    );

    // Next-state and registered-output logic; everything holds while ena is low
    always_comb begin
        state_d      = state_q;
        load_en_d    = load_en_q;
        weight_nib_d = weight_nib_q;
        busy_d       = busy_q;
        done_d       = done_q;
        neuron_idx_d = neuron_idx_q;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        if (ena) begin
            if (abort) begin
                // Abort beats start; the core may be left mid-byte
                state_d   = ST_IDLE;
                load_en_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                w_flush   = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        load_en_d = 1'b0;
                        done_d    = 1'b0;
                        if (start) begin
                            neuron_idx_d = '0;
                            busy_d       = 1'b1;
                            state_d      = ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        done_d = 1'b0;
                        // Only start a byte when both nibbles are in hand
                        if (!w_fifo_empty) begin
                            load_en_d    = 1'b1;
                            weight_nib_d = w_head[3:0];
                            state_d      = ST_HIGH;
                        end else begin
                            load_en_d = 1'b0;
                        end
                    end
                    ST_HIGH: begin
                        load_en_d    = 1'b1;
                        weight_nib_d = w_head[7:4];
                        w_pop        = 1'b1;
                        neuron_idx_d = neuron_idx_q + IDX_W'(1);
                        state_d      = (neuron_idx_q == LAST_IDX) ? ST_DONE : ST_LOW;
                    end
                    ST_DONE: begin
                        load_en_d = 1'b0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        load_en_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            load_en_q    <= 1'b0;
            weight_nib_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            neuron_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            load_en_q    <= load_en_d;
            weight_nib_q <= weight_nib_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            neuron_idx_q <= neuron_idx_d;
        end
    end

    assign load_en    = load_en_q;
    assign weight_nib = weight_nib_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign neuron_idx = neuron_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_weight_streamer
// Brief    : Self-checking bench: nibble scoreboard plus a model of the core's
//            weight loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bnn_weight_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       start;
    logic       abort;
    logic       load_en;
    logic [3:0] weight_nib;
    logic       busy;
    logic       done;
    logic [4:0] neuron_idx;

    bnn_weight_streamer #(
        .NUM_NEURONS (12),
        .FIFO_DEPTH  (4),
        .IDX_W       (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .start      (start),
        .abort      (abort),
        .load_en    (load_en),
        .weight_nib (weight_nib),
        .busy       (busy),
        .done       (done),
        .neuron_idx (neuron_idx)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  exp_q [$];
    logic [7:0]  frame_b [12];
    logic [7:0]  m_w [16];
    int          m_cnt, done_cnt, run, max_run, gap_cnt, load_cnt, hist_n;
    logic        m_phase;
    logic [3:0]  m_low;
    logic [3:0]  mon_e;
    logic [31:0] nib_hist;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and core-loader model; the core samples only while ena is high
    always @(negedge clk) begin
        if (rst_n && ena) begin
            if (done) done_cnt++;
            if (load_en) begin
                load_cnt++;
                run++;
                if (run > max_run) max_run = run;
                if (hist_n < 8) begin
                    nib_hist = {nib_hist[27:0], weight_nib};
                    hist_n++;
                end
                if (exp_q.size() == 0) begin
                    chk("nib_unexpected", 32'(load_en), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("nib", 32'(weight_nib), 32'(mon_e));
                end
                if (!m_phase) begin
                    m_low   = weight_nib;
                    m_phase = 1'b1;
                end else begin
                    if (m_cnt < 16) m_w[m_cnt] = {weight_nib, m_low};
                    m_cnt++;
                    m_phase = 1'b0;
                end
            end else begin
                run = 0;
                if (busy && m_phase) chk("mid_byte_gap", 32'(m_phase), 32'd0);
                if (busy && m_cnt > 0) gap_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc = 0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        s_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
        if (acc) begin
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
        end
    endtask

    task automatic feed(input int from, input int to);
        for (int i = from; i <= to; i++) push_byte(frame_b[i]);
    endtask

    task automatic pulse_start();
        m_cnt = 0; m_phase = 0; done_cnt = 0; run = 0; max_run = 0;
        gap_cnt = 0; hist_n = 0; nib_hist = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // Find the cycle where the low nibble of neuron idx is on the pins (state HIGH)
    task automatic wait_high_at(input int idx, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (load_en && !m_phase && neuron_idx == 5'(idx)) ok = 1;
        end
    endtask

    task automatic end_checks(input string tag);
        wait_done();
        tick();
        tick();
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_idx"}, 32'(neuron_idx), 32'd12);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_core_cnt"}, 32'(m_cnt), 32'd12);
        for (int i = 0; i < 12; i++) chk({tag, "_weight"}, 32'(m_w[i]), 32'(frame_b[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int dc, lc;
        logic [11:0] snap;
        rst_n = 1'b0; ena = 1'b1; s_valid = 1'b0; s_data = '0;
        start = 1'b0; abort = 1'b0;
        m_cnt = 0; m_phase = 0; done_cnt = 0; run = 0; max_run = 0;
        gap_cnt = 0; load_cnt = 0; hist_n = 0; nib_hist = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'({load_en, weight_nib, busy, done, neuron_idx}), 32'd0);
        chk("reset_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // 1: prefill four bytes, stream the rest without stalls
        frame_b = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h5A, 8'hA5,
                    8'hFF, 8'h00, 8'h81, 8'h42, 8'h24, 8'h18};
        feed(0, 3);
        fork
            pulse_start();
            feed(4, 11);
        join
        end_checks("prefill");
        chk("first_nibbles", nib_hist, 32'h0E0783C1);
        chk("load_run", 32'(max_run), 32'd24);

        // 2: random frame from an empty FIFO into the loader model
        for (int i = 0; i < 12; i++) frame_b[i] = 8'($urandom);
        fork
            pulse_start();
            feed(0, 11);
        join
        end_checks("random");

        // 3: host withholds byte 5 for three cycles
        for (int i = 0; i < 12; i++) frame_b[i] = 8'($urandom);
        fork
            pulse_start();
            begin
                feed(0, 4);
                ok = 0;
                for (int i = 0; i < 300 && !ok; i++) begin
                    @(negedge clk);
                    if (neuron_idx == 5'd5) ok = 1;
                end
                chk("underrun_reach", 32'(ok), 32'd1);
                tick();
                repeat (3) tick();
                feed(5, 11);
            end
        join
        end_checks("underrun");
        // three withheld cycles, one for the push to land, one for the registered output
        chk("underrun_gap", 32'(gap_cnt), 32'd5);

        // 4: ena low for five cycles while a low nibble is on the pins
        for (int i = 0; i < 12; i++) frame_b[i] = 8'($urandom);
        feed(0, 3);
        fork
            feed(4, 11);
            begin
                pulse_start();
                wait_high_at(6, ok);
                chk("ena_reach", 32'(ok), 32'd1);
                ena  = 1'b0;
                snap = {load_en, weight_nib, busy, done, neuron_idx};
                chk("ena_s_ready", 32'(s_ready), 32'd0);
                repeat (5) begin
                    @(negedge clk);
                    chk("ena_hold", 32'({load_en, weight_nib, busy, done, neuron_idx}), 32'(snap));
                end
                tick();
                ena = 1'b1;
            end
        join
        end_checks("ena");

        // 5: abort in HIGH at neuron 3, then a start with no data
        for (int i = 0; i < 12; i++) frame_b[i] = 8'($urandom);
        feed(0, 3);
        fork
            pulse_start();
            feed(4, 5);
        join
        wait_high_at(3, ok);
        chk("abort_reach", 32'(ok), 32'd1);
        dc = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        m_phase = 0;
        m_cnt = 0;
        chk("abort_load_en", 32'(load_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd1);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(dc));
        lc = load_cnt;
        pulse_start();
        repeat (10) tick();
        chk("abort_empty_load", 32'(load_cnt), 32'(lc));
        chk("abort_empty_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("abort_clear", 32'(busy), 32'd0);

        // 6a: asynchronous reset mid-frame
        for (int i = 0; i < 12; i++) frame_b[i] = 8'($urandom);
        feed(0, 3);
        pulse_start();
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({load_en, weight_nib, busy, done, neuron_idx}), 32'd0);
        chk("async_rst_s_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // 6b: start together with abort stays idle, even with data queued
        push_byte(8'h3C);
        push_byte(8'hC3);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_load", 32'(load_en), 32'd0);
        chk("start_abort_flush", 32'(s_ready), 32'd1);

        // 6c: push while full is refused and the byte is lost
        frame_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                    8'h77, 8'h88, 8'h99, 8'hBB, 8'hCC, 8'hDD};
        feed(0, 3);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        tick();
        tick();
        s_valid = 1'b0;
        fork
            pulse_start();
            feed(4, 11);
        join
        end_checks("full");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
